// File: rtl/logic_unit_fifo.sv
// Registered bitwise logic unit feeding a DEPTH-entry result FIFO with zero/parity flags.
// Optional accepted-op counter enabled by defining LOGIC_UNIT_STATS_EN.
module logic_unit_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_parity
`ifdef LOGIC_UNIT_STATS_EN
   ,
   output logic [CNT_W-1:0] op_count
`endif
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   if (WIDTH < 1 || WIDTH > 64 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1)
   begin : g_param_check
      $error("logic_unit_fifo: illegal parameter set");
   end

   logic [WIDTH+1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic [WIDTH-1:0] w_result;
   logic [WIDTH+1:0] w_entry;
   logic [WIDTH+1:0] w_head;
   logic             w_push;
   logic             w_pop;

   always_comb begin
      w_result = '0;
      case (in_op)
         3'd0: w_result = in_a & in_b;
         3'd1: w_result = in_a | in_b;
         3'd2: w_result = ~(in_a & in_b);
         3'd3: w_result = ~(in_a | in_b);
         3'd4: w_result = in_a ^ in_b;
         3'd5: w_result = ~(in_a ^ in_b);
         3'd6: w_result = ~in_a;
         3'd7: w_result = in_a;
      endcase
   end

   // Entry layout: {parity, zero, result}
   assign w_entry = {^w_result, ~|w_result, w_result};

   assign in_ready  = (r_count != FULL_CNT);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Storage is unreset; outputs are masked while empty so reset values stay zero.
   assign w_head     = r_mem[r_rd_ptr];
   assign out_result = out_valid ? w_head[WIDTH-1:0] : '0;
   assign out_zero   = out_valid && w_head[WIDTH];
   assign out_parity = out_valid && w_head[WIDTH+1];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef LOGIC_UNIT_STATS_EN
   logic [CNT_W-1:0] r_op_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (w_push && (r_op_count != '1)) begin
         r_op_count <= r_op_count + 1'b1;
      end
   end

   assign op_count = r_op_count;
`endif

endmodule

// File: doc/logic_unit_fifo.md
Name: logic_unit_fifo

Overview:
- Parametrised, registered successor to the combinational gate-level logic demo.
- Applies one of eight bitwise operations to two WIDTH-bit operands and queues each result, with zero and parity flags, in a DEPTH-entry output FIFO.
- Input and output use valid/ready handshakes, so the block sits between a stimulus source and a consumer that may stall.

Parameters:
WIDTH, 8, operand/result width in bits (1..64)
DEPTH, 4, output FIFO entries (power of two, >= 2)
CNT_W, 16, width of op counter (optional feature only)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand presented
in_ready  output  1  block can accept operands
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  3  operation select
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_result  output  WIDTH  head result
out_zero  output  1  head result == 0
out_parity  output  1  XOR-reduction of head result
op_count  output  CNT_W  accepted-op count (only with LOGIC_UNIT_STATS_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n: assertion acts immediately, release is sampled on clk.
- Reset values: FIFO empty, out_valid=0, in_ready=1, out_result=0, out_zero=0, out_parity=0, op_count=0. Read/write pointers and occupancy are 0.
- in_op encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A (in_b ignored), 7 PASS A. All codes are defined.
- Push:
  - Occurs when in_valid && in_ready at a clk edge.
  - The result, zero flag and parity flag are computed combinationally from the sampled inputs and written into the FIFO entry together.
- Pop: occurs when out_valid && out_ready at a clk edge; the head advances.
- Latency: an op accepted at edge N into an empty FIFO has out_valid=1 with its result right after edge N. There is no combinational in->out path.
- Ordering: results leave in acceptance order; none are dropped or duplicated.
- in_ready = !full. It depends only on registered occupancy, never on out_ready.
  - When full, no push is possible even if a pop occurs in the same cycle. in_ready rises the cycle after the pop.
- out_valid = !empty. out_result, out_zero and out_parity always reflect the head entry. They must hold stable while out_valid && !out_ready.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy is unchanged, both pointers advance.
- Push when empty: out_valid rises next cycle. There is no pop, since out_valid was 0.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by an occupancy counter of log2(DEPTH)+1 bits.
- Input protocol: in_valid may drop without a handshake; the block must not capture data unless in_ready=1.
- Reset mid-operation: all entries are discarded, outputs return to reset values asynchronously, and the first push after release behaves as from power-up.
- Width rules:
  - All ops are bitwise at WIDTH.
  - out_zero=1 iff all result bits are 0.
  - out_parity=1 iff an odd number of result bits are 1.

Optional Feature:
LOGIC_UNIT_STATS_EN
- Defined:
  - op_count port exists.
  - It increments by 1 on every push and saturates at 2^CNT_W-1 (no wrap).
  - Reset to 0 by rst_n.
  - Simultaneous pop has no effect on it.
- Not defined:
  - op_count port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then WIDTH=8: push a=8'h0F b=8'h3C for op 0..7 with out_ready=1 -> results 0C,3F,F3,C0,33,CC,F0,0F. Flags: zero=0 on all eight; parity 0,0,0,0,0,0,0,0.
- a=8'hAA b=8'h55 op=0 -> result 00, out_zero=1, out_parity=0. Same operands op=4 -> result FF, out_zero=0, out_parity=0. a=8'h01 op=7 -> parity=1.
- Full and stall: out_ready=0, push 5 ops with DEPTH=4 -> 4 accepted, in_ready=0 after the 4th, 5th held. Raise out_ready for one cycle -> one pop; in_ready=1 the following cycle; 5th accepted. Output order matches input order.
- Steady streaming: in_valid=1, out_ready=1 with occupancy 2 for 20 cycles -> occupancy stays 2, one result per cycle, no gaps.
- Backpressure hold: out_valid=1, out_ready=0 for 7 cycles while in_a/in_b toggle -> out_result and flags stable throughout.
- Reset mid-stream: with 3 entries queued, pulse rst_n low between edges -> out_valid=0 immediately. After release, one push a=8'h12 op=7 -> out_result 12 on the next cycle. With LOGIC_UNIT_STATS_EN, op_count=1. Separately, run 2^CNT_W+3 pushes with CNT_W=4 -> op_count=15.
